// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: instruction-memory request/acknowledge bus between fetch and imem.
interface fetch_pc_unit_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [79:0] imem_data;
  logic        imem_err;
  modport master (output imem_req, imem_addr, input imem_ack, imem_data, imem_err);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_data, imem_err);
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: Y86-64 SEQ fetch stage holding the PC, fetching a 10-byte window and decoding it.
module fetch_pc_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          IMEM_BYTES = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [63:0]            newPC,
  input  logic                   pc_load,
  fetch_pc_unit_if.master        imem,
  output logic [63:0]            pc,
  output logic [3:0]             icode,
  output logic [3:0]             ifun,
  output logic [3:0]             rA,
  output logic [3:0]             rB,
  output logic [63:0]            valC,
  output logic [63:0]            valP,
  output logic                   instr_valid,
  output logic [1:0]             stat
);
  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;
  if (IMEM_BYTES != 10) begin : g_bytes_check
    $error("fetch_pc_unit: IMEM_BYTES must be 10");
  end
  typedef enum logic [1:0] {S_RST, S_FETCH, S_VALID, S_HALTED} state_t;
  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [3:0]  icode_q, icode_d, ifun_q, ifun_d, ra_q, ra_d, rb_q, rb_d;
  logic [63:0] valc_q, valc_d, valp_q, valp_d;
  logic [1:0]  stat_q, stat_d;
  logic        capture, take_pc;
  logic [3:0]  dec_icode, dec_ifun, dec_len;
  logic        dec_has_reg, dec_ins, dec_bad;
  logic [1:0]  dec_stat;
  logic [63:0] dec_valc;
  always_ff @(posedge clk) state_q <= reset ? S_RST : state_d;
  always_comb begin
    state_d = state_q == S_RST   ? S_FETCH
            : state_q == S_FETCH ? (imem.imem_ack ? S_VALID : S_FETCH)
            : state_q == S_VALID ? (stat_q != STAT_AOK ? S_HALTED : pc_load ? S_FETCH : S_VALID)
            : S_HALTED;
  end
  always_comb begin
    imem.imem_req  = state_q == S_FETCH;
    imem.imem_addr = pc_q;
    instr_valid    = state_q == S_VALID || state_q == S_HALTED;
  end
  always_comb begin
    dec_icode = imem.imem_data[7:4];
    dec_ifun  = imem.imem_data[3:0];
    case (dec_icode)
      4'h2, 4'h6, 4'hA, 4'hB: dec_len = 4'd2;
      4'h3, 4'h4, 4'h5:       dec_len = 4'd10;
      4'h7, 4'h8:             dec_len = 4'd9;
      default:                dec_len = 4'd1;
    endcase
    dec_has_reg = dec_icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    dec_ins = dec_icode > 4'hB
           || (dec_icode == 4'h6 && dec_ifun > 4'h3)
           || ((dec_icode == 4'h2 || dec_icode == 4'h7) && dec_ifun > 4'h6)
           || (!(dec_icode inside {4'h2, 4'h6, 4'h7}) && dec_ifun != 4'h0);
    dec_stat = imem.imem_err ? STAT_ADR : dec_ins ? STAT_INS
             : dec_icode == 4'h0 ? STAT_HLT : STAT_AOK;
    dec_bad  = dec_stat == STAT_ADR || dec_stat == STAT_INS;
    dec_valc = dec_icode inside {4'h3, 4'h4, 4'h5} ? imem.imem_data[79:16]
             : dec_icode inside {4'h7, 4'h8}       ? imem.imem_data[71:8]
             : 64'd0;
  end
  // Faulting instructions keep icode/ifun but expose no operands and do not advance valP.
  always_comb begin
    capture = state_q == S_FETCH && imem.imem_ack;
    take_pc = state_q == S_VALID && stat_q == STAT_AOK && pc_load;
    pc_d    = take_pc ? newPC : pc_q;
    icode_d = capture ? dec_icode : icode_q;
    ifun_d  = capture ? dec_ifun : ifun_q;
    ra_d    = capture ? (dec_has_reg && !dec_bad ? imem.imem_data[15:12] : 4'hF) : ra_q;
    rb_d    = capture ? (dec_has_reg && !dec_bad ? imem.imem_data[11:8] : 4'hF) : rb_q;
    valc_d  = capture ? (dec_bad ? 64'd0 : dec_valc) : valc_q;
    valp_d  = capture ? (dec_bad ? pc_q : pc_q + {60'd0, dec_len}) : valp_q;
    stat_d  = capture ? dec_stat : stat_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      icode_q <= 4'h0;
      ifun_q  <= 4'h0;
      ra_q    <= 4'hF;
      rb_q    <= 4'hF;
      valc_q  <= 64'd0;
      valp_q  <= 64'd0;
      stat_q  <= STAT_AOK;
    end else begin
      pc_q    <= pc_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      valc_q  <= valc_d;
      valp_q  <= valp_d;
      stat_q  <= stat_d;
    end
  end
  assign pc    = pc_q;
  assign icode = icode_q;
  assign ifun  = ifun_q;
  assign rA    = ra_q;
  assign rB    = rb_q;
  assign valC  = valc_q;
  assign valP  = valp_q;
  assign stat  = stat_q;
endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Fetch stage of the SEQ Y86-64 core. Holds the architectural PC register and fetches a 10-byte instruction window from instruction memory over a req/ack handshake. Splits out icode/ifun/rA/rB/valC, computes valP and fetch status. Consumes newPC from pcupdate on commit and feeds icode/ifun/valC/valP back to pcupdate.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
IMEM_BYTES, 10, instruction window width in bytes; fixed at 10 and checked at elaboration.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
newPC  in  64  next PC from pcupdate.
pc_load  in  1  commit strobe: current instruction retired, take newPC.
imem_req  out  1  fetch request.
imem_addr  out  64  fetch address (= pc).
imem_ack  in  1  memory response valid.
imem_data  in  80  bytes pc..pc+9; byte k at [8k+7:8k].
imem_err  in  1  address error, qualified by imem_ack.
pc  out  64  current PC register.
icode  out  4  instruction code.
ifun  out  4  function code.
rA  out  4  register A, 4'hF if unused.
rB  out  4  register B, 4'hF if unused.
valC  out  64  constant word, 0 if unused.
valP  out  64  pc + instruction length.
instr_valid  out  1  decoded fields valid.
stat  out  2  0=AOK, 1=HLT, 2=ADR, 3=INS.

Behaviour:
- Reset: pc=RESET_PC, imem_req=0, instr_valid=0, stat=0, icode/ifun=0, rA=rB=4'hF, valC=0, valP=0. Reset wins over every other input. Reset mid-handshake drops imem_req on the next cycle and discards any ack.
- State machine, registered: RST -> FETCH -> VALID -> FETCH ... and VALID -> HALTED.
  - RST: one cycle after reset deasserts, then FETCH.
  - FETCH: imem_req=1, imem_addr=pc held stable until imem_ack is sampled high. Data and err are captured on that edge. Next state is VALID with instr_valid=1. Ack in the first req cycle is legal, so minimum latency is req cycle -> valid next cycle.
  - VALID: outputs held stable. pc_load=1 -> pc<=newPC, instr_valid<=0, state FETCH, so req rises the following cycle. If stat!=AOK, VALID goes to HALTED.
  - HALTED: instr_valid=1 and stat held; no req; pc_load ignored; left only by reset.
- imem_ack outside FETCH and pc_load outside VALID are ignored.
- Decode of captured window: icode=byte0[7:4], ifun=byte0[3:0].
- Instruction lengths: 0 halt=1, 1 nop=1, 2 cmovXX=2, 3 irmovq=10, 4 rmmovq=10, 5 mrmovq=10, 6 OPq=2, 7 jXX=9, 8 call=9, 9 ret=1, A pushq=2, B popq=2.
- Register byte (byte1) is present for 2,3,4,5,6,A,B: rA=[7:4], rB=[3:0]. Otherwise rA=rB=F.
- valC, little-endian: bytes 2..9 for icode 3/4/5; bytes 1..8 for icode 7/8; otherwise 0.
- valP = pc + length, modulo 2^64 (wraps, no flag).
- stat priority:
  - ADR if imem_err.
  - else INS if icode>B, or ifun>3 for OPq, or ifun>6 for cmov/jXX, or ifun!=0 for any other icode.
  - else HLT if icode=0.
  - else AOK.
- On ADR or INS: icode/ifun are still reported, rA=rB=F, valC=0, valP=pc.

Test Plan:
- Reset then ack on first req cycle with byte0=8'h30, byte1=8'hF2, bytes2..9=64'd100 -> next cycle instr_valid=1, icode=3, rA=F, rB=2, valC=100, valP=10, stat=0.
- VALID with pc=0, newPC=64'd100, pc_load=1 -> next cycle pc=100, instr_valid=0, imem_req=1, imem_addr=100. Ack delayed 3 cycles with 8'h70 + dest 64'd300 -> icode=7, valC=300, valP=109.
- pc=64'hFFFF_FFFF_FFFF_FFFE, ret (8'h90) -> valP=64'hFFFF_FFFF_FFFF_FFFF. Same pc with irmovq -> valP=64'd8 (wrap).
- byte0=8'h00 -> stat=1. Then pc_load pulses and stray imem_ack -> pc, stat and all outputs unchanged, imem_req stays 0.
- byte0=8'h65 -> stat=3, valP=pc. byte0=8'hC0 -> stat=3. imem_err=1 with valid opcode -> stat=2. Each ends in HALTED.
- reset=1 during FETCH with req pending, ack arriving in the same cycle -> next cycle pc=RESET_PC, imem_req=0, instr_valid=0, stat=0.
